// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states and ISA constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH_BOOT,
    FETCH_RUN,
    FETCH_FAULT
  } fetch_state_t;

  localparam logic [31:0] ARM_NOP     = 32'hD503201F;
  localparam int          INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with async reset; qualifies a candidate next PC as
// word-aligned and fully inside the instruction ROM.
module fetch_pc_reg
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                MEM_SIZE = 1024,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] next_pc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_ok_o
);

  // Comparing against MEM_SIZE-3 avoids the wrap that next_pc+3 would suffer
  // for targets near the top of the address space.
  localparam logic [ADDR_W-1:0] PC_LIMIT = ADDR_W'(MEM_SIZE - INSTR_BYTES + 1);

  logic [ADDR_W-1:0] pc_q;

  assign pc_ok_o = (next_pc_i[1:0] == 2'b00) && (next_pc_i < PC_LIMIT);
  assign pc_o    = pc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
    end else if (en_i) begin
      pc_q <= next_pc_i;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives the ROM address from the PC, captures instructions into
// the IF/ID register, and handles stalls, redirects and fetch faults.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter int                MEM_SIZE = 1024,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid,
  output logic               fetch_fault,
  output logic [31:0]        fetch_count
);

  if (MEM_SIZE <= 4 || (MEM_SIZE & (MEM_SIZE - 1)) != 0) begin : g_bad_mem_size
    $error("instr_fetch_unit: MEM_SIZE must be a power of two greater than 4");
  end

  localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(ARM_NOP);

  fetch_state_t       state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ifpc_q, ifpc_d;
  logic               valid_q, valid_d;
  logic [31:0]        count_q, count_d;

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  next_pc;
  logic               pc_en;
  logic               pc_ok;

  // The bounds check always looks at the candidate the mux would load, so a
  // bad redirect target and running off the ROM end share one comparator.
  assign next_pc = redirect ? redirect_pc : pc + ADDR_W'(INSTR_BYTES);

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .MEM_SIZE (MEM_SIZE),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .en_i      (pc_en),
    .next_pc_i (next_pc),
    .pc_o      (pc),
    .pc_ok_o   (pc_ok)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    count_d = count_q;
    pc_en   = 1'b0;
    unique case (state_q)
      FETCH_BOOT: begin
        state_d = FETCH_RUN;
      end
      FETCH_RUN: begin
        if (redirect) begin
          instr_d = NOP_W;
          valid_d = 1'b0;
          if (pc_ok) pc_en = 1'b1;
          else       state_d = FETCH_FAULT;
        end else if (!stall) begin
          instr_d = imem_instr;
          ifpc_d  = pc;
          valid_d = 1'b1;
          count_d = count_q + 32'd1;
          if (pc_ok) pc_en = 1'b1;
          else       state_d = FETCH_FAULT;
        end
      end
      FETCH_FAULT: begin
        instr_d = NOP_W;
        valid_d = 1'b0;
      end
      default: begin
        state_d = FETCH_FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH_BOOT;
      instr_q <= NOP_W;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ifpc_q;
  assign if_id_valid = valid_q;
  assign fetch_fault = (state_q == FETCH_FAULT);
  assign fetch_count = count_q;

endmodule
